conv_win_sched: RTL and testbench
=================================

// Module: conv_win_sched
// PURPOSE
//  Sequencer for the 7x7 convolution core. Walks every output position of every filter and
//  issues one core enable per window when the window/weight fetcher is ready.
//  Tracks in-flight results across the core's fixed pipeline latency and writes each valid
//  16-bit result to the feature-map buffer at its linear address. Sits between the layer
//  top FSM (start/done), the window fetcher and the result memory.
// PARAMETERS
//  IMG_W     28  input feature-map width = height (pixels)
//  KER       7   kernel edge; OUT_DIM = IMG_W-KER+1 (stride 1, no padding)
//  NUM_FILT  4   filters per layer, filter-major issue order
//  LAT       10  core enable->valid latency (cycles)
//  ADDR_W    16  result address width; must hold NUM_FILT*OUT_DIM*OUT_DIM-1
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       async active-low reset
//  start       in   1       1-cycle pulse: begin layer; ignored unless IDLE
//  busy        out  1       high from accepted start until done
//  done        out  1       1-cycle pulse, last result written
//  win_row     out  8       top row of current window
//  win_col     out  8       left column of current window
//  filt_sel    out  8       current filter index (weight/bias bank select)
//  win_rdy     in   1       fetcher has ima/wei/bias for (filt_sel,win_row,win_col) on core inputs
//  core_enable out  1       issue strobe to conv core
//  core_valid  in   1       conv core result valid
//  core_out    in   16      conv core saturated Q8.8 result
//  res_we      out  1       result write strobe
//  res_addr    out  ADDR_W  f*OUT_DIM^2 + r*OUT_DIM + c
//  res_data    out  16      written result
//  err         out  2       sticky: [0] valid with nothing outstanding, [1] drain timeout
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, state IDLE, err cleared. Reset mid-layer aborts; no done.
//  States: IDLE -start-> RUN -last issue-> DRAIN -outstanding==0-> DONE -> IDLE.
//  IDLE: busy=0; start loads pos counters to (0,0,0); busy=1 next cycle; clears err.
//  RUN: core_enable = win_rdy (combinational, same cycle); on issue col++, wrap at OUT_DIM ->
//   row++, wrap -> filt++. Issue with (NUM_FILT-1,OUT_DIM-1,OUT_DIM-1) moves to DRAIN.
//   win_rdy low = stall; counters hold; no bubble after win_rdy returns.
//  Outstanding counter (width clog2(LAT+2)): +1 issue, -1 core_valid, both same cycle = hold.
//  core_valid with outstanding==0: err[0] set, no write, counter stays 0.
//  Write path: res_we/res_addr/res_data registered, one cycle after core_valid; write counter
//   increments per accepted valid, res_addr = write counter (order matches issue order).
//  DRAIN: core_enable=0; cycle counter resets on each core_valid; reaching LAT+2 without valid
//   sets err[1] and forces DONE. DONE: done=1 for one cycle (after final res_we), busy drops
//   in same cycle, back to IDLE. start in RUN/DRAIN/DONE ignored.
//  Throughput: one window per cycle when win_rdy held high; layer time = N_issue + LAT + 2.
// CONFIGURATION
//  CONV_SCHED_RELU_EN defined: res_data = core_out[15] ? 16'h0000 : core_out.
//  Not defined: res_data = core_out unchanged. Address/timing identical either way.
// STRUCTURE
//  conv_sched_pkg: state enum (IDLE,RUN,DRAIN,DONE), OUT_DIM function, clog2 helper,
//   err bit index constants.
//  Sub-module conv_pos_cnt: nested col/row/filt counters with advance input, last flag.
// TESTING (IMG_W=9, KER=7 -> OUT_DIM=3, NUM_FILT=2, LAT=10; core model = 10-stage delay)
//  1 win_rdy=1 constant, start -> 18 enables in 18 consecutive cycles, 18 writes addr 0..17
//    in order, done 1 cycle after last res_we, err=0.
//  2 win_rdy random 50% -> same 18 addr/data pairs; counters hold exactly on stall cycles.
//  3 core_out=16'hFF00 on addr 5: RELU_EN -> 0x0000 written; without -> 0xFF00 written.
//  4 spurious core_valid in IDLE -> err[0]=1, no res_we; cleared by next start.
//  5 core model drops last valid -> err[1] set 12 cycles after last valid, done still pulses.
//  6 rst_n low at issue 7 -> all outputs 0 async; new start replays from addr 0, 18 writes.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the convolution window scheduler.
// Optional ReLU on written results is enabled by defining CONV_SCHED_RELU_EN.
package conv_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int ERR_SPUR = 0;
    localparam int ERR_TMO  = 1;

    function automatic int out_dim(input int img_w, input int ker);
        return img_w - ker + 1;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_pos_cnt.sv
// Nested column/row/filter position counters for window issue order.
// Column is innermost, filter outermost; last_o flags the final window.
module conv_pos_cnt
    import conv_sched_pkg::*;
#(
    parameter int OUT_DIM  = 22,
    parameter int NUM_FILT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       adv_i,
    output logic [7:0] col_o,
    output logic [7:0] row_o,
    output logic [7:0] filt_o,
    output logic       last_o
);

    logic [7:0] col_q, col_d;
    logic [7:0] row_q, row_d;
    logic [7:0] filt_q, filt_d;
    logic       col_end, row_end, filt_end;

    assign col_end  = (col_q == 8'(OUT_DIM - 1));
    assign row_end  = (row_q == 8'(OUT_DIM - 1));
    assign filt_end = (filt_q == 8'(NUM_FILT - 1));
    assign last_o   = col_end && row_end && filt_end;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        filt_d = filt_q;
        if (clr_i) begin
            col_d  = '0;
            row_d  = '0;
            filt_d = '0;
        end else if (adv_i) begin
            col_d = col_end ? 8'd0 : col_q + 8'd1;
            if (col_end) begin
                row_d = row_end ? 8'd0 : row_q + 8'd1;
                if (row_end) filt_d = filt_end ? 8'd0 : filt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            filt_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            filt_q <= filt_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign filt_o = filt_q;

endmodule

// File: rtl/conv_win_sched.sv
// Window issue sequencer and result writer for the 7x7 convolution core.
// Define CONV_SCHED_RELU_EN to clamp negative results to zero on write.
module conv_win_sched
    import conv_sched_pkg::*;
#(
    parameter int IMG_W    = 28,
    parameter int KER      = 7,
    parameter int NUM_FILT = 4,
    parameter int LAT      = 10,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [7:0]        win_row,
    output logic [7:0]        win_col,
    output logic [7:0]        filt_sel,
    input  logic              win_rdy,
    output logic              core_enable,
    input  logic              core_valid,
    input  logic [15:0]       core_out,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [15:0]       res_data,
    output logic [1:0]        err
);

    localparam int OUT_DIM = out_dim(IMG_W, KER);
    localparam int CW      = clog2(LAT + 2);
    localparam int DW      = CW + 1;
    localparam logic [DW-1:0] TMO_CNT = DW'(LAT + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     out_q, out_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [1:0]        err_q, err_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       data_q;
    logic [15:0]       wdata;
    logic              issue, accept, clr, last;

    assign issue  = (state_q == RUN) && win_rdy;
    assign accept = core_valid && (out_q != '0);
    assign clr    = (state_q == IDLE) && start;

    conv_pos_cnt #(
        .OUT_DIM (OUT_DIM),
        .NUM_FILT(NUM_FILT)
    ) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .adv_i (issue),
        .col_o (win_col),
        .row_o (win_row),
        .filt_o(filt_sel),
        .last_o(last)
    );

`ifdef CONV_SCHED_RELU_EN
    assign wdata = core_out[15] ? 16'h0000 : core_out;
`else
    assign wdata = core_out;
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        dcnt_d  = dcnt_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        if (issue && !accept) out_d = out_q + CW'(1);
        else if (!issue && accept) out_d = out_q - CW'(1);
        if (core_valid && !accept) err_d[ERR_SPUR] = 1'b1;
        if (accept) wcnt_d = wcnt_q + ADDR_W'(1);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    err_d   = '0;
                    out_d   = '0;
                    wcnt_d  = '0;
                end
            end
            RUN: begin
                dcnt_d = DW'(1);
                if (issue && last) state_d = DRAIN;
            end
            DRAIN: begin
                dcnt_d = core_valid ? DW'(1) : dcnt_q + DW'(1);
                if (out_q == '0) begin
                    state_d = DONE;
                end else if (!core_valid && dcnt_q == TMO_CNT) begin
                    // a result never arrived: give up rather than hang the layer
                    err_d[ERR_TMO] = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                out_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            dcnt_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            dcnt_q  <= dcnt_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            we_q    <= accept;
            if (accept) begin
                addr_q <= wcnt_q;
                data_q <= wdata;
            end
        end
    end

    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign core_enable = issue;
    assign res_we      = we_q;
    assign res_addr    = addr_q;
    assign res_data    = data_q;
    assign err         = err_q;

endmodule

// File: tb/tb_conv_win_sched.sv
// Randomized bench for conv_win_sched with a queue-based layer model.
// Honors CONV_SCHED_RELU_EN for the expected write data.
module tb_conv_win_sched;

    localparam int LAT = 10;
    localparam int OD  = 3;
    localparam int NW  = 18;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic        busy, done, core_enable, core_valid, res_we;
    logic [7:0]  win_row, win_col, filt_sel;
    logic        win_rdy = 0;
    logic [15:0] core_out, res_addr, res_data;
    logic [1:0]  err;

    conv_win_sched #(
        .IMG_W(9), .KER(7), .NUM_FILT(2), .LAT(LAT), .ADDR_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .win_row(win_row), .win_col(win_col), .filt_sel(filt_sel),
        .win_rdy(win_rdy), .core_enable(core_enable),
        .core_valid(core_valid), .core_out(core_out),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // core model: output is a function of the window index it was enabled on
    logic [7:0] salt = 8'h3c;
    int drop_idx = -1;
    logic spur = 0;
    int rdy_mode = 0;

    function automatic logic [15:0] core_fn(input int idx);
        logic [15:0] v;
        v = {salt ^ 8'(idx * 37), 8'(idx)};
        if (idx == 5) v = 16'hFF00;
        return v;
    endfunction

    function automatic logic [15:0] exp_data(input int idx);
        logic [15:0] v;
        v = core_fn(idx);
`ifdef CONV_SCHED_RELU_EN
        if (v[15]) v = 16'h0000;
`endif
        return v;
    endfunction

    int idx_now;
    logic [LAT-1:0] vpipe;
    logic [15:0] dpipe [LAT];
    assign idx_now    = int'(filt_sel) * OD * OD + int'(win_row) * OD + int'(win_col);
    assign core_valid = vpipe[LAT-1] | spur;
    assign core_out   = dpipe[LAT-1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[LAT-2:0], core_enable && (idx_now != drop_idx)};
            dpipe[0] <= core_fn(idx_now);
            for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) win_rdy = 1'($urandom_range(0, 1));
    end

    // layer model: issue index, in-flight queue, expected next-cycle outputs
    int iss = 0;
    int n_wr = 0;
    int last_evt = 0;
    int q[$];
    logic m_busy = 0, m_done = 0, m_we = 0;
    logic n_busy, n_done, n_we;
    logic [15:0] m_addr, m_data;
    logic [1:0] m_err = 0, n_err;
    logic exp_en;
    logic [7:0] e_f, e_r, e_c;

    // per-layer statistics for literal checks
    int en_cnt, first_en, last_en, we_cnt, last_we, last_valid, done_cyc, err1_cyc, start_cyc;

    task automatic clr_stats();
        en_cnt = 0; first_en = -1; last_en = -1; we_cnt = 0; last_we = -1;
        last_valid = -1; done_cyc = -1; err1_cyc = -1; start_cyc = -1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_we", res_we, 0);
            chk("rst_err", err, 0);
            m_busy = 0; m_done = 0; m_we = 0; m_err = 0;
            iss = 0; n_wr = 0; q.delete();
        end else begin
            exp_en = m_busy && (iss < NW) && win_rdy;
            if (m_busy && iss < NW) begin
                e_f = 8'(iss / (OD * OD)); e_r = 8'((iss / OD) % OD); e_c = 8'(iss % OD);
            end else begin
                e_f = 0; e_r = 0; e_c = 0;
            end
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("core_enable", core_enable, exp_en);
            chk("pos", {filt_sel, win_row, win_col}, {e_f, e_r, e_c});
            chk("err", err, m_err);
            chk("res_we", res_we, m_we);
            if (m_we) begin
                chk("res_addr", res_addr, m_addr);
                chk("res_data", res_data, m_data);
            end
            if (core_enable) begin
                en_cnt++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (res_we) begin
                we_cnt++;
                last_we = cyc;
                if (res_addr == 16'd5) begin
`ifdef CONV_SCHED_RELU_EN
                    chk("addr5_lit", res_data, 16'h0000);
`else
                    chk("addr5_lit", res_data, 16'hFF00);
`endif
                end
            end
            if (core_valid) last_valid = cyc;
            if (done) done_cyc = cyc;
            if (err[1] && err1_cyc < 0) err1_cyc = cyc;

            n_busy = m_busy; n_done = 0; n_we = 0; n_err = m_err;
            if (!m_busy && !m_done && start) begin
                start_cyc = cyc;
                n_busy = 1; n_err = 0; iss = 0; n_wr = 0; q.delete();
            end else begin
                if (m_busy && iss >= NW) begin
                    if (q.size() == 0) begin
                        n_done = 1; n_busy = 0;
                    end else if (!core_valid && cyc - last_evt == LAT + 1) begin
                        n_err[1] = 1; n_done = 1; n_busy = 0;
                    end
                end
                if (core_valid) begin
                    if (q.size() > 0) begin
                        int idx;
                        idx = q.pop_front();
                        n_we = 1; m_addr = 16'(n_wr); m_data = exp_data(idx);
                        n_wr++;
                    end else begin
                        n_err[0] = 1;
                    end
                    last_evt = cyc;
                end
                if (m_busy && iss < NW) begin
                    last_evt = cyc;
                    if (exp_en) begin
                        q.push_back(iss);
                        iss++;
                    end
                end
                if (m_done) q.delete();
            end
            m_busy = n_busy; m_done = n_done; m_we = n_we; m_err = n_err;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_done(input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", (k < lim), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        clr_stats();
        #1;
        chk("reset_done", done, 0);
        chk("reset_enable", core_enable, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);

        // 1: win_rdy held high
        clr_stats(); salt = 8'($urandom); win_rdy = 1; rdy_mode = 1;
        pulse_start();
        wait_done(200);
        chk("t1_en_cnt", en_cnt, NW);
        chk("t1_en_span", last_en - first_en, NW - 1);
        chk("t1_we_cnt", we_cnt, NW);
        chk("t1_done_after_we", done_cyc - last_we, 1);
        chk("t1_layer_time", done_cyc - start_cyc, NW + LAT + 2);

        // 2: random stalls
        repeat (3) begin
            clr_stats(); salt = 8'($urandom); rdy_mode = 2;
            pulse_start();
            wait_done(500);
            chk("t2_en_cnt", en_cnt, NW);
            chk("t2_we_cnt", we_cnt, NW);
        end
        rdy_mode = 0; win_rdy = 0;

        // 4: spurious valid while idle
        clr_stats();
        @(posedge clk); #1 spur = 1;
        @(posedge clk); #1 spur = 0;
        @(posedge clk); #1;
        chk("t4_err_spur", err, 2'b01);
        chk("t4_no_write", we_cnt, 0);
        win_rdy = 1; rdy_mode = 1;
        pulse_start();
        chk("t4_err_cleared", err, 2'b00);
        wait_done(200);

        // 5: last result never comes back
        clr_stats(); drop_idx = NW - 1;
        pulse_start();
        wait_done(200);
        chk("t5_err_tmo", err[1], 1);
        chk("t5_tmo_delay", err1_cyc - last_valid, 12);
        chk("t5_we_cnt", we_cnt, NW - 1);
        drop_idx = -1;
        repeat (2) @(posedge clk);

        // 6: reset in mid-layer, then a full replay
        clr_stats();
        pulse_start();
        for (int k = 0; k < 100 && en_cnt < 7; k++) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("t6_async_busy", busy, 0);
        chk("t6_async_en", core_enable, 0);
        chk("t6_async_pos", {filt_sel, win_row, win_col}, 0);
        chk("t6_async_we", res_we, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        clr_stats(); rdy_mode = 2;
        pulse_start();
        wait_done(500);
        chk("t6_we_cnt", we_cnt, NW);
        chk("t6_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
